// File: rtl/e_md_unit.sv
// Purpose : E-stage multiply/divide unit; runs mult/multu/div/divu and holds results in HI/LO,
//           also services mthi/mtlo.
// Latency : mult/multu commit MULT_CYCLES edges after accept, div/divu DIV_CYCLES edges;
//           mthi/mtlo write on the accepting edge.
// Backpressure: no handshake; busy (with start) stalls later md instructions in the D stage,
//               and any md_op seen while busy is dropped.
//
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   md_op[2:0]       : 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   rs_data, rt_data : forwarded operands
//   start            : combinational, md_op is 1..4 while the unit is idle
//   busy             : registered, operation in flight
//   hi, lo           : architectural HI/LO registers
module e_md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e             state_q;
   logic               busy_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [31:0]        hi_q, lo_q;
   logic [31:0]        tmp_hi_q, tmp_lo_q;
   logic               wb_en_q;

   logic [31:0]        tmp_hi_d, tmp_lo_d;
   logic               wb_en_d;
   logic               is_mul;

   // ---------------- arithmetic, evaluated on the operands present at the accept edge
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic               div_signed, neg_a, neg_b, div_zero;
   logic [31:0]        mag_a, mag_b, div_b, uq, ur, quot, rem;

   assign prod_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
   assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

   // Signed divide is done on magnitudes, then signs are reapplied: quotient truncates toward
   // zero, remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000 rem 0.
   assign div_signed = (md_op == OP_DIV);
   assign neg_a      = div_signed & rs_data[31];
   assign neg_b      = div_signed & rt_data[31];
   assign mag_a      = neg_a ? (~rs_data + 32'd1) : rs_data;
   assign mag_b      = neg_b ? (~rt_data + 32'd1) : rt_data;
   assign div_zero   = (rt_data == 32'd0);
   // Divisor forced nonzero so the divider never sees 0; the result is discarded anyway.
   assign div_b      = div_zero ? 32'd1 : mag_b;
   assign uq         = mag_a / div_b;
   assign ur         = mag_a % div_b;
   assign quot       = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
   assign rem        = neg_a ? (~ur + 32'd1) : ur;

   assign is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);

   always_comb begin
      tmp_hi_d = tmp_hi_q;
      tmp_lo_d = tmp_lo_q;
      wb_en_d  = wb_en_q;
      case (md_op)
         OP_MULT: begin
            tmp_hi_d = prod_s[63:32];
            tmp_lo_d = prod_s[31:0];
            wb_en_d  = 1'b1;
         end
         OP_MULTU: begin
            tmp_hi_d = prod_u[63:32];
            tmp_lo_d = prod_u[31:0];
            wb_en_d  = 1'b1;
         end
         OP_DIV, OP_DIVU: begin
            tmp_hi_d = rem;
            tmp_lo_d = quot;
            // Divide by zero still occupies the unit but leaves HI/LO untouched.
            wb_en_d  = ~div_zero;
         end
         default: ;
      endcase
   end

   assign start = (state_q == S_IDLE) && (md_op >= OP_MULT) && (md_op <= OP_DIVU);
   assign busy  = busy_q;
   assign hi    = hi_q;
   assign lo    = lo_q;

   // ---------------- control FSM and architectural state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         tmp_hi_q <= '0;
         tmp_lo_q <= '0;
         wb_en_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  tmp_hi_q <= tmp_hi_d;
                  tmp_lo_q <= tmp_lo_d;
                  wb_en_q  <= wb_en_d;
                  cnt_q    <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                  busy_q   <= 1'b1;
                  state_q  <= S_RUN;
               end else if (md_op == OP_MTHI) begin
                  hi_q <= rs_data;
               end else if (md_op == OP_MTLO) begin
                  lo_q <= rs_data;
               end
            end
            S_RUN: begin
               // md_op is deliberately not looked at here: anything arriving while busy is dropped.
               if (cnt_q == CNT_W'(1)) begin
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
                  wb_en_q <= 1'b0;
                  if (wb_en_q) begin
                     hi_q <= tmp_hi_q;
                     lo_q <= tmp_lo_q;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/e_md_unit.md
Name: e_md_unit

Overview:
- Multiply/divide unit in the E stage, alongside the ALU, driven by the same E-stage instruction decode.
- Executes mult, multu, div, divu over a fixed multi-cycle latency and holds results in HI/LO. Also services mthi and mtlo.
- Exposes `busy` so the D-stage hazard unit stalls any later md instruction (including mfhi/mflo) until results are ready.

Parameters:
- MULT_CYCLES, 5, cycles `busy` stays high after a mult/multu is accepted (≥1).
- DIV_CYCLES, 10, cycles `busy` stays high after a div/divu is accepted (≥1).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- md_op  input  3  E-stage md operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- rs_data  input  32  forwarded rs operand (dividend / multiplicand / mthi/mtlo source)
- rt_data  input  32  forwarded rt operand (divisor / multiplier)
- start  output  1  combinational: high when md_op is 1–4 and unit is idle (hazard unit uses start|busy)
- busy  output  1  registered: operation in flight
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset: synchronous, highest priority, aborts any operation in flight. busy=0, hi=0, lo=0, counter=0, pending result discarded.
- States: IDLE (busy=0) and RUN (busy=1). A down-counter of ≥4 bits tracks the cycles remaining.
- Accept: on an edge in IDLE with md_op∈{1..4}:
  - compute the 64-bit result into internal registers tmp_hi/tmp_lo from operands sampled at that edge;
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - set busy=1.
- RUN:
  - each edge decrements the counter;
  - on the edge where the counter equals 1: busy←0, hi←tmp_hi, lo←tmp_lo, return to IDLE.
  - busy is therefore high for exactly N cycles after the accept edge, and hi/lo change on the same edge busy falls.
- md_op while busy: any nonzero md_op (including mthi/mtlo) is ignored. The hazard unit guarantees none arrives, but the unit must not corrupt state if one does.
- mthi/mtlo in IDLE: hi (or lo) ← rs_data on that edge. busy stays 0; the other register is unchanged.
- Arithmetic:
  - mult: signed 32×32 → 64; hi=upper, lo=lower.
  - multu: unsigned 32×32 → 64.
  - div: lo=quotient truncated toward zero; hi=remainder with the dividend's sign.
  - divu: unsigned quotient/remainder.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (32-bit wrap).
- Divide by zero (rt_data=0, div or divu): hi/lo are left unchanged at completion, but busy still asserts for the full DIV_CYCLES.
- Back-to-back: a new md_op accepted in the cycle right after busy falls is legal, and its operands may use the just-written hi/lo values.
- start is never high while busy is high.
- hi/lo hold their values between operations. No other update paths exist.

Test Plan:
- Reset, then mult rs=0xFFFFFFFE (-2), rt=3 → busy high for 5 cycles; on the fall edge hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy=0, start=0 afterwards with md_op=0.
- multu rs=0xFFFFFFFF, rt=0xFFFFFFFF → after 5 cycles hi=0xFFFFFFFE, lo=0x00000001. div rs=-7 (0xFFFFFFF9), rt=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu same operands → lo=0x7FFFFFFC, hi=1.
- Preload hi=0x11, lo=0x22 via mthi/mtlo (each takes effect next edge, busy stays 0); then div rt=0 → busy high 10 cycles; afterwards hi=0x11, lo=0x22.
- Start mult, then drive mtlo rs=0xDEAD and divu on cycles 2–3 of busy → both ignored, and the mult result lands at cycle 5 unchanged.
- Start div, assert reset at cycle 4 → next edge busy=0, hi=lo=0, and no late writeback occurs over the following 10 cycles.
- Back-to-back: mult completes, next cycle div issues → start=1 on that cycle, busy rises next edge, and the second result is correct.
